// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants for the DMEM responder: MMIO register
//               offsets, STATUS bit layout, counter width and a small
//               saturation helper for the STATUS occupancy field.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Cycle counter / snapshot width
    localparam int CNT_W = 32;

    // MMIO register offsets relative to MMIO_BASE
    localparam logic [15:0] OFF_SNAP_LO  = 16'd0;
    localparam logic [15:0] OFF_SNAP_HI  = 16'd1;
    localparam logic [15:0] OFF_OUT_PORT = 16'd2;
    localparam logic [15:0] OFF_STATUS   = 16'd3;

    // STATUS register bit positions
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_OVF       = 1;
    localparam int STAT_COUNT_LSB = 2;

    // Occupancy as reported in STATUS: three bits, saturating at 7 so deeper
    // FIFOs still fit the fixed register layout.
    function automatic logic [2:0] sat3(input int unsigned n);
        logic [2:0] r;
        if (n > 32'd7) begin
            r = 3'd7;
        end else begin
            r = n[2:0];
        end
        return r;
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : out_fifo
// Description : Synchronous FIFO with an extra pointer bit for full/empty
//               disambiguation. A push while full is accepted only when a pop
//               happens in the same cycle; otherwise it is reported on drop_o.
//               The head word reads as zero while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module out_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic                       drop_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             do_pop;
    logic             do_push;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push_i && (!full || do_pop);

    assign drop_o  = push_i && !do_push;
    assign empty_o = empty;
    assign count_o = count;
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance for accepted pushes and pops
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since empty masks the head
    always_ff @(posedge clk_i) begin
        if (rst_ni && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule : out_fifo
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : DMEM-side responder for the 16-bit processor. Addresses below
//               MMIO_BASE hit a word RAM (aliased on the low ADDR_W bits);
//               addresses at/above MMIO_BASE hit the cycle-counter snapshot,
//               the output FIFO port and the STATUS register. Reads are
//               combinational; all writes land on the rising clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter logic [15:0] MMIO_BASE  = 16'hFF00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] DMEM_ADDRESS,
    input  logic [15:0] DMEM_DATA_WRITE,
    input  logic        DMEM_WRITE_ENABLE,
    output logic [15:0] DMEM_DATA_READ,
    output logic [15:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]      ram_q [2**ADDR_W];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic             ovf_q, ovf_d;

    logic             is_mmio;
    logic [15:0]      mmio_off;
    logic             snap_wr;
    logic             stat_wr;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_drop;
    logic [CW-1:0]    fifo_count;
    logic [15:0]      fifo_head;
    logic [15:0]      status;

    assign is_mmio  = (DMEM_ADDRESS >= MMIO_BASE);
    assign mmio_off = DMEM_ADDRESS - MMIO_BASE;
    assign snap_wr  = DMEM_WRITE_ENABLE && is_mmio && (mmio_off == OFF_SNAP_LO);
    assign stat_wr  = DMEM_WRITE_ENABLE && is_mmio && (mmio_off == OFF_STATUS);
    // Writes presented during reset are discarded
    assign push     = RESET && DMEM_WRITE_ENABLE && is_mmio && (mmio_off == OFF_OUT_PORT);
    assign pop      = OUT_VALID && OUT_READY;

    out_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .push_i  (push),
        .data_i  (DMEM_DATA_WRITE),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop),
        .count_o (fifo_count)
    );

    assign OUT_DATA  = fifo_head;
    assign OUT_VALID = !fifo_empty;

    // STATUS register layout: saturated count, sticky overflow, empty flag
    always_comb begin
        status                            = '0;
        status[STAT_EMPTY]                = fifo_empty;
        status[STAT_OVF]                  = ovf_q;
        status[STAT_COUNT_LSB +: 3]       = sat3(32'(fifo_count));
    end

    // Zero-latency read mux; same-cycle writes are not yet visible
    always_comb begin
        DMEM_DATA_READ = '0;
        if (!is_mmio) begin
            DMEM_DATA_READ = ram_q[DMEM_ADDRESS[ADDR_W-1:0]];
        end else begin
            case (mmio_off)
                OFF_SNAP_LO: DMEM_DATA_READ = snap_q[15:0];
                OFF_SNAP_HI: DMEM_DATA_READ = snap_q[31:16];
                OFF_STATUS:  DMEM_DATA_READ = status;
                default:     DMEM_DATA_READ = '0;
            endcase
        end
    end

    // Next-state for counter, snapshot and sticky overflow (set beats clear)
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        snap_d = snap_q;
        ovf_d  = ovf_q;
        if (snap_wr) begin
            snap_d = cnt_q;
        end
        if (stat_wr) begin
            ovf_d = 1'b0;
        end
        if (fifo_drop) begin
            ovf_d = 1'b1;
        end
    end

    // MMIO state registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt_q  <= '0;
            snap_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
            ovf_q  <= ovf_d;
        end
    end

    // Word RAM; contents survive reset but reset-cycle writes are dropped
    always_ff @(posedge CLK) begin
        if (RESET && DMEM_WRITE_ENABLE && !is_mmio) begin
            ram_q[DMEM_ADDRESS[ADDR_W-1:0]] <= DMEM_DATA_WRITE;
        end
    end

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. FIFO words are pushed
//               to an expected-value queue as they are written and popped and
//               compared as the consumer side accepts them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        we = 1'b0;
    logic [15:0] rdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] exp_q [$];

    dmem_responder #(
        .ADDR_W     (8),
        .MMIO_BASE  (16'hFF00),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK               (clk),
        .RESET             (rst_n),
        .DMEM_ADDRESS      (addr),
        .DMEM_DATA_WRITE   (wdata),
        .DMEM_WRITE_ENABLE (we),
        .DMEM_DATA_READ    (rdata),
        .OUT_DATA          (out_data),
        .OUT_VALID         (out_valid),
        .OUT_READY         (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired: passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    // Push a FIFO word and record it for the scoreboard
    task automatic push_exp(input logic [15:0] d);
        wr(16'hFF02, d);
        exp_q.push_back(d);
    endtask

    // Consume n words with OUT_READY high, checking each against the queue
    task automatic drain(input int n);
        int got = 0;
        logic [15:0] e;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < n + 8 && got < n; cyc++) begin
            #1;
            if (out_valid) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL drain_unexpected got %h required nothing", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) $display("FAIL drain_data got %h required %h", out_data, e);
                    else n_pass++;
                end
                got++;
            end
            tick();
        end
        out_ready = 1'b0;
        n_total++;
        if (got != n) $display("FAIL drain_count got %0d required %0d", got, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst_n = 1'b0;
        tick();
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b required 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 16'h0) $display("FAIL rst_data got %h required 0000", out_data); else n_pass++;
        rd(16'hFF03, v);
        n_total++; if (v !== 16'h0001) $display("FAIL rst_status got %h required 0001", v); else n_pass++;
        rd(16'hFF00, v);
        n_total++; if (v !== 16'h0000) $display("FAIL rst_snaplo got %h required 0000", v); else n_pass++;
        rd(16'hFF01, v);
        n_total++; if (v !== 16'h0000) $display("FAIL rst_snaphi got %h required 0000", v); else n_pass++;
        rd(16'hFF07, v);
        n_total++; if (v !== 16'h0000) $display("FAIL rst_unmapped got %h required 0000", v); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_ram();
        logic [15:0] v;
        wr(16'h0010, 16'h5555);
        addr  = 16'h0010;
        wdata = 16'h1234;
        we    = 1'b1;
        #1;
        n_total++; if (rdata !== 16'h5555) $display("FAIL ram_same_cycle got %h required 5555", rdata); else n_pass++;
        tick();
        we = 1'b0;
        rd(16'h0010, v);
        n_total++; if (v !== 16'h1234) $display("FAIL ram_read got %h required 1234", v); else n_pass++;
        rd(16'h0110, v);
        n_total++; if (v !== 16'h1234) $display("FAIL ram_alias got %h required 1234", v); else n_pass++;
        wr(16'h00FF, 16'hBEEF);
        rd(16'hFEFF, v);
        n_total++; if (v !== 16'hBEEF) $display("FAIL ram_top_alias got %h required beef", v); else n_pass++;
        rd(16'hFF02, v);
        n_total++; if (v !== 16'h0000) $display("FAIL outport_read got %h required 0000", v); else n_pass++;
    endtask

    task automatic test_snapshot();
        logic [15:0] v;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        wr(16'hFF00, 16'h0000);
        rd(16'hFF00, v);
        n_total++; if (v !== 16'h000A) $display("FAIL snap_lo got %h required 000a", v); else n_pass++;
        rd(16'hFF01, v);
        n_total++; if (v !== 16'h0000) $display("FAIL snap_hi got %h required 0000", v); else n_pass++;
        wr(16'hFF01, 16'hFFFF);
        tick();
        tick();
        rd(16'hFF00, v);
        n_total++; if (v !== 16'h000A) $display("FAIL snap_stable got %h required 000a", v); else n_pass++;
        rd(16'hFF01, v);
        n_total++; if (v !== 16'h0000) $display("FAIL snap_hi_write_ignored got %h required 0000", v); else n_pass++;
    endtask

    task automatic test_fifo();
        logic [15:0] v;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(16'hA1 + 16'(i));
        rd(16'hFF03, v);
        n_total++; if (v !== 16'h0010) $display("FAIL fifo_status_full got %h required 0010", v); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL fifo_valid got %b required 1", out_valid); else n_pass++;
        n_total++; if (out_data !== 16'h00A1) $display("FAIL fifo_head got %h required 00a1", out_data); else n_pass++;
        tick();
        tick();
        n_total++; if (out_data !== 16'h00A1 || out_valid !== 1'b1)
            $display("FAIL fifo_hold got %h/%b required 00a1/1", out_data, out_valid); else n_pass++;
        drain(4);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL fifo_empty_valid got %b required 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 16'h0) $display("FAIL fifo_empty_data got %h required 0000", out_data); else n_pass++;
        rd(16'hFF03, v);
        n_total++; if (v !== 16'h0001) $display("FAIL fifo_status_empty got %h required 0001", v); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [15:0] v;
        logic [15:0] e;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(16'hC0 + 16'(i));
        wr(16'hFF02, 16'h00BB);
        rd(16'hFF03, v);
        n_total++; if (v !== 16'h0012) $display("FAIL ovf_set got %h required 0012", v); else n_pass++;
        wr(16'hFF03, 16'h0000);
        rd(16'hFF03, v);
        n_total++; if (v !== 16'h0010) $display("FAIL ovf_clear got %h required 0010", v); else n_pass++;
        // Push while full with a simultaneous pop
        addr      = 16'hFF02;
        wdata     = 16'h00CC;
        we        = 1'b1;
        out_ready = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_total++; if (out_data !== e) $display("FAIL ovf_pop_data got %h required %h", out_data, e); else n_pass++;
        exp_q.push_back(16'h00CC);
        tick();
        we        = 1'b0;
        out_ready = 1'b0;
        rd(16'hFF03, v);
        n_total++; if (v !== 16'h0010) $display("FAIL ovf_pushpop_status got %h required 0010", v); else n_pass++;
        drain(4);
    endtask

    task automatic test_wrap();
        logic [15:0] v;
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        wr(16'hFF00, 16'h0000);
        rd(16'hFF00, v);
        n_total++; if (v !== 16'hFFFE) $display("FAIL wrap_pre_lo got %h required fffe", v); else n_pass++;
        rd(16'hFF01, v);
        n_total++; if (v !== 16'hFFFF) $display("FAIL wrap_pre_hi got %h required ffff", v); else n_pass++;
        tick();
        wr(16'hFF00, 16'h0000);
        rd(16'hFF00, v);
        n_total++; if (v !== 16'h0000) $display("FAIL wrap_lo got %h required 0000", v); else n_pass++;
        rd(16'hFF01, v);
        n_total++; if (v !== 16'h0000) $display("FAIL wrap_hi got %h required 0000", v); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        logic [15:0] e;
        wr(16'h0020, 16'h7777);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(16'hD0 + 16'(i));
        wr(16'hFF02, 16'h00BB);
        out_ready = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_total++; if (out_data !== e) $display("FAIL mid_pop_data got %h required %h", out_data, e); else n_pass++;
        tick();
        out_ready = 1'b0;
        rd(16'hFF03, v);
        n_total++; if (v !== 16'h000E) $display("FAIL mid_status_pre got %h required 000e", v); else n_pass++;
        rst_n = 1'b0;
        addr  = 16'h0020;
        wdata = 16'hDEAD;
        we    = 1'b1;
        tick();
        rst_n = 1'b1;
        we    = 1'b0;
        exp_q.delete();
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_valid got %b required 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 16'h0) $display("FAIL mid_data got %h required 0000", out_data); else n_pass++;
        rd(16'hFF03, v);
        n_total++; if (v !== 16'h0001) $display("FAIL mid_status got %h required 0001", v); else n_pass++;
        rd(16'h0020, v);
        n_total++; if (v !== 16'h7777) $display("FAIL mid_ram_kept got %h required 7777", v); else n_pass++;
        rd(16'hFF00, v);
        n_total++; if (v !== 16'h0000) $display("FAIL mid_snap_cleared got %h required 0000", v); else n_pass++;
        tick();
        tick();
        tick();
        wr(16'hFF00, 16'h0000);
        rd(16'hFF00, v);
        n_total++; if (v !== 16'h0003) $display("FAIL mid_counter_restart got %h required 0003", v); else n_pass++;
        rd(16'hFF01, v);
        n_total++; if (v !== 16'h0000) $display("FAIL mid_counter_hi got %h required 0000", v); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_snapshot();
        test_fifo();
        test_overflow();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
